// File: rtl/strided_buf_pkg.sv
// Shared constants, state encoding and config check for the strided ping-pong loader.
package strided_buf_pkg;

  // Bit positions of the packed frame shape {c, h, w}
  localparam int C_MSB = 31;
  localparam int C_LSB = 20;
  localparam int H_MSB = 19;
  localparam int H_LSB = 10;
  localparam int W_MSB = 9;
  localparam int W_LSB = 0;

  localparam logic MODE_STRIDED = 1'b0;
  localparam logic MODE_BCAST   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // A shape is usable only if it has at least one word of channels, one row and one column.
  function automatic logic shape_ok(input logic [31:0] shape, input int log2_cpw);
    logic [C_MSB-C_LSB:0] n_c;
    n_c = shape[C_MSB:C_LSB] >> log2_cpw;
    return (n_c != '0) && (shape[H_MSB:H_LSB] != '0) && (shape[W_MSB:W_LSB] != '0);
  endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
module bram_sdp #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port; contents are never cleared
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; output register resets to zero so the reader sees 0 until the first read
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/strided_pingpong_buffer.sv
// Loads a channel/y/x ordered activation stream into N_BANK double-buffered RAM banks.
module strided_pingpong_buffer
  import strided_buf_pkg::*;
#(
  parameter int N_BANK           = 5,
  parameter int HALF_DEPTH       = 256,
  parameter int B_HADDR          = $clog2(HALF_DEPTH),
  parameter int DATA_WIDTH       = 64,
  parameter int B_COORD          = 10,
  parameter int LOG2_CH_PER_WORD = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [31:0]                    cfg_shape,
  input  logic                           cfg_mode,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  output logic                           frame_done,
  output logic                           cfg_err,
  output logic                           ovf,
  output logic                           rd_valid,
  input  logic                           rd_release,
  input  logic [N_BANK*B_HADDR-1:0]      rd_addr,
  output logic [N_BANK*DATA_WIDTH-1:0]   rd_data
);

  localparam int SEL_W = (N_BANK > 1) ? $clog2(N_BANK) : 1;

  state_e state_q, state_d;
  logic [31:0] shape_q, shape_d;
  logic mode_q, mode_d;
  logic [B_COORD-1:0] c_cnt_q, c_cnt_d, y_cnt_q, y_cnt_d, x_cnt_q, x_cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic wr_half_q, wr_half_d, rd_half_q, rd_half_d;
  logic [1:0] full_q, full_d;
  logic ovf_q, ovf_d, frame_done_q, frame_done_d;
  logic [B_HADDR-1:0] waddr_q [N_BANK];
  logic [B_HADDR-1:0] waddr_d [N_BANK];
  // Set once a bank has written its last half address in the current frame
  logic [N_BANK-1:0] top_q, top_d;
  // One-stage write pipeline towards the RAMs
  logic [N_BANK-1:0] we_p_q, we_p_d;
  logic [B_HADDR:0] addr_p_q [N_BANK];
  logic [B_HADDR:0] addr_p_d [N_BANK];
  logic [DATA_WIDTH-1:0] data_p_q, data_p_d;
  logic last_p_q, last_p_d, last_half_p_q, last_half_p_d;

  logic accept, last_c, last_y, last_x;
  logic [C_MSB-C_LSB:0] n_c;

  assign n_c    = shape_q[C_MSB:C_LSB] >> LOG2_CH_PER_WORD;
  assign last_c = (32'(c_cnt_q) == 32'(n_c) - 32'd1);
  assign last_y = (32'(y_cnt_q) == 32'(shape_q[H_MSB:H_LSB]) - 32'd1);
  assign last_x = (32'(x_cnt_q) == 32'(shape_q[W_MSB:W_LSB]) - 32'd1);
  assign accept = s_valid && s_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: start always restarts, landing in ERR when the new shape is unusable
  always_comb begin
    state_d = state_q;
    if (start) state_d = shape_ok(cfg_shape, LOG2_CH_PER_WORD) ? ST_RUN : ST_ERR;
  end

  // State-decoded outputs
  always_comb begin
    s_ready = (state_q == ST_RUN) && !full_q[wr_half_q];
    cfg_err = (state_q == ST_ERR);
  end

  // Counters, bank steering, half bookkeeping and write pipeline input
  always_comb begin
    shape_d = shape_q;  mode_d = mode_q;
    c_cnt_d = c_cnt_q;  y_cnt_d = y_cnt_q;  x_cnt_d = x_cnt_q;  sel_d = sel_q;
    wr_half_d = wr_half_q;  rd_half_d = rd_half_q;  full_d = full_q;  ovf_d = ovf_q;
    waddr_d = waddr_q;  top_d = top_q;
    we_p_d = '0;  addr_p_d = addr_p_q;  data_p_d = data_p_q;
    last_p_d = 1'b0;  last_half_p_d = last_half_p_q;  frame_done_d = 1'b0;

    // The pipelined last beat commits its half; the other half may be released in the same cycle
    if (last_p_q) begin
      full_d[last_half_p_q] = 1'b1;
      frame_done_d = 1'b1;
    end
    if (rd_release && full_q[rd_half_q]) begin
      full_d[rd_half_q] = 1'b0;
      rd_half_d = !rd_half_q;
    end

    if (accept) begin
      data_p_d = s_data;
      for (int b = 0; b < N_BANK; b++) begin
        if (mode_q == MODE_BCAST || sel_q == SEL_W'(b)) begin
          if (top_q[b]) begin
            ovf_d = 1'b1;
          end else begin
            we_p_d[b]   = 1'b1;
            addr_p_d[b] = {wr_half_q, waddr_q[b]};
            waddr_d[b]  = waddr_q[b] + 1'b1;
            top_d[b]    = (waddr_q[b] == B_HADDR'(HALF_DEPTH - 1));
          end
        end
      end
      if (!last_c) begin
        c_cnt_d = c_cnt_q + 1'b1;
      end else begin
        c_cnt_d = '0;
        if (!last_y) begin
          y_cnt_d = y_cnt_q + 1'b1;
        end else begin
          y_cnt_d = '0;
          if (!last_x) begin
            x_cnt_d = x_cnt_q + 1'b1;
            sel_d   = (sel_q == SEL_W'(N_BANK - 1)) ? '0 : sel_q + 1'b1;
          end else begin
            x_cnt_d = '0;
            sel_d   = '0;
            wr_half_d = !wr_half_q;
            last_p_d  = 1'b1;
            last_half_p_d = wr_half_q;
            for (int b = 0; b < N_BANK; b++) waddr_d[b] = '0;
            top_d = '0;
          end
        end
      end
    end

    // Restart discards any partial frame, including a beat still in the pipeline
    if (start) begin
      shape_d = cfg_shape;  mode_d = cfg_mode;
      c_cnt_d = '0;  y_cnt_d = '0;  x_cnt_d = '0;  sel_d = '0;
      wr_half_d = 1'b0;  rd_half_d = 1'b0;  full_d = '0;  ovf_d = 1'b0;
      for (int b = 0; b < N_BANK; b++) waddr_d[b] = '0;
      top_d = '0;  we_p_d = '0;  last_p_d = 1'b0;  frame_done_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shape_q <= '0;  mode_q <= MODE_STRIDED;
      c_cnt_q <= '0;  y_cnt_q <= '0;  x_cnt_q <= '0;  sel_q <= '0;
      wr_half_q <= 1'b0;  rd_half_q <= 1'b0;  full_q <= '0;
      ovf_q <= 1'b0;  frame_done_q <= 1'b0;
      top_q <= '0;  we_p_q <= '0;  data_p_q <= '0;
      last_p_q <= 1'b0;  last_half_p_q <= 1'b0;
      for (int b = 0; b < N_BANK; b++) begin
        waddr_q[b]  <= '0;
        addr_p_q[b] <= '0;
      end
    end else begin
      shape_q <= shape_d;  mode_q <= mode_d;
      c_cnt_q <= c_cnt_d;  y_cnt_q <= y_cnt_d;  x_cnt_q <= x_cnt_d;  sel_q <= sel_d;
      wr_half_q <= wr_half_d;  rd_half_q <= rd_half_d;  full_q <= full_d;
      ovf_q <= ovf_d;  frame_done_q <= frame_done_d;
      top_q <= top_d;  we_p_q <= we_p_d;  data_p_q <= data_p_d;
      last_p_q <= last_p_d;  last_half_p_q <= last_half_p_d;
      waddr_q  <= waddr_d;
      addr_p_q <= addr_p_d;
    end
  end

  assign ovf        = ovf_q;
  assign frame_done = frame_done_q;
  assign rd_valid   = full_q[rd_half_q];

  generate
    for (genvar gi = 0; gi < N_BANK; gi++) begin : g_bank
      bram_sdp #(
        .DEPTH (2 * HALF_DEPTH),
        .AW    (B_HADDR + 1),
        .DW    (DATA_WIDTH)
      ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we_p_q[gi]),
        .waddr (addr_p_q[gi]),
        .wdata (data_p_q),
        .raddr ({rd_half_q, rd_addr[gi*B_HADDR +: B_HADDR]}),
        .rdata (rd_data[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_strided_pingpong_buffer.sv
// Self-checking bench for strided_pingpong_buffer: model memory plus read scoreboard.
module tb_strided_pingpong_buffer;

  localparam int NB = 5;
  localparam int HD = 256;
  localparam int HA = 8;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst, start, cfg_mode, s_valid, s_ready, frame_done, cfg_err, ovf, rd_valid, rd_release;
  logic [31:0] cfg_shape;
  logic [DW-1:0] s_data;
  logic [NB*HA-1:0] rd_addr;
  logic [NB*DW-1:0] rd_data;

  strided_pingpong_buffer #(
    .N_BANK(NB), .HALF_DEPTH(HD), .B_HADDR(HA), .DATA_WIDTH(DW),
    .B_COORD(10), .LOG2_CH_PER_WORD(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_shape(cfg_shape), .cfg_mode(cfg_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .frame_done(frame_done),
    .cfg_err(cfg_err), .ovf(ovf), .rd_valid(rd_valid), .rd_release(rd_release),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bank;
    logic [63:0] exp;
    string       tag;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [63:0] mdl [NB][2][HD];
  int          wcnt [NB];
  int          wr_half_m;
  int          n_checks = 0;
  int          n_fail = 0;
  int          fd_count = 0;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] shape, input logic mode);
    cfg_shape = shape;
    cfg_mode  = mode;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_half_m = 0;
    for (int b = 0; b < NB; b++) wcnt[b] = 0;
    $display("start shape=%h mode=%0d", shape, mode);
  endtask

  task automatic push_beat(input logic [63:0] d);
    int waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) chk("ready_timeout", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Drives beats [first, limit) of a frame in c-fastest, y, x order and records them in the model
  task automatic send_frame(input logic mode, input int c, input int h, input int w,
                            input logic [63:0] base, input int first, input int limit);
    int n_c = c >> 2;
    int idx = 0;
    for (int x = 0; x < w; x++)
      for (int y = 0; y < h; y++)
        for (int cc = 0; cc < n_c; cc++) begin
          if (idx >= first && idx < limit) begin
            for (int b = 0; b < NB; b++) begin
              if (mode == 1'b1 || b == (x % NB)) begin
                if (wcnt[b] < HD) mdl[b][wr_half_m][wcnt[b]] = base + 64'(idx);
                wcnt[b]++;
              end
            end
            push_beat(base + 64'(idx));
          end
          idx++;
        end
    if (limit >= n_c * h * w) begin
      wr_half_m ^= 1;
      for (int b = 0; b < NB; b++) wcnt[b] = 0;
    end
    $display("beats %0d..%0d sent base=%h mode=%0d", first, limit - 1, base, mode);
  endtask

  // Called at the negedge right after the last beat was accepted
  task automatic expect_commit(input string tag);
    chk({tag, "_fd_t1"}, 64'(frame_done), 64'd0);
    @(negedge clk);
    chk({tag, "_fd_t2"}, 64'(frame_done), 64'd1);
    chk({tag, "_rdv_t2"}, 64'(rd_valid), 64'd1);
    @(negedge clk);
    chk({tag, "_fd_t3"}, 64'(frame_done), 64'd0);
  endtask

  // Issues reads for banks [0, nb) and scores the data one cycle later
  task automatic read_check(input int half, input int a0, input int n, input int nb, input string tag);
    sb_entry_t e;
    for (int a = a0; a < a0 + n; a++) begin
      for (int b = 0; b < nb; b++) begin
        rd_addr[b*HA +: HA] = HA'(a);
        sb.push_back('{bank: b, exp: mdl[b][half][a], tag: $sformatf("%s_b%0d_a%0d", tag, b, a)});
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, rd_data[e.bank*DW +: DW], e.exp);
      end
    end
    $display("read %s half=%0d addr %0d..%0d", tag, half, a0, a0 + n - 1);
  endtask

  task automatic pulse_release();
    rd_release = 1'b1;
    @(negedge clk);
    rd_release = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    rst = 1'b1; start = 1'b0; cfg_shape = '0; cfg_mode = 1'b0;
    s_valid = 1'b0; s_data = '0; rd_release = 1'b0; rd_addr = '0;
    wr_half_m = 0;
    for (int b = 0; b < NB; b++) wcnt[b] = 0;
    repeat (3) @(negedge clk);
    chk("rst_rd_data0", rd_data[63:0], 64'd0);
    chk("rst_rd_data4", rd_data[4*DW +: DW], 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);

    // Strided: c=8 (2 words), h=2, w=5 -> four words per bank
    do_start({12'd8, 10'd2, 10'd5}, 1'b0);
    chk("str_s_ready", 64'(s_ready), 64'd1);
    send_frame(1'b0, 8, 2, 5, 64'h1100, 0, 20);
    expect_commit("str");
    read_check(0, 0, 4, NB, "str");

    // Broadcast: every bank receives all 20 words
    do_start({12'd8, 10'd2, 10'd5}, 1'b1);
    chk("bc_rd_valid_cleared", 64'(rd_valid), 64'd0);
    send_frame(1'b1, 8, 2, 5, 64'h2200, 0, 20);
    expect_commit("bc");
    read_check(0, 0, 20, NB, "bc");

    // Ping-pong: two frames fill both halves, release exposes the second one
    do_start({12'd8, 10'd2, 10'd5}, 1'b0);
    send_frame(1'b0, 8, 2, 5, 64'h3300, 0, 20);
    expect_commit("ppA");
    send_frame(1'b0, 8, 2, 5, 64'h4400, 0, 20);
    chk("ppB_s_ready_full", 64'(s_ready), 64'd0);
    expect_commit("ppB");
    chk("ppB_s_ready_held", 64'(s_ready), 64'd0);
    pulse_release();
    chk("pp_rel_s_ready", 64'(s_ready), 64'd1);
    chk("pp_rel_rd_valid", 64'(rd_valid), 64'd1);
    read_check(1, 0, 4, NB, "ppB");
    pulse_release();
    chk("pp_rel2_rd_valid", 64'(rd_valid), 64'd0);
    pulse_release();
    chk("pp_rel_ignored", 64'(rd_valid), 64'd0);
    send_frame(1'b0, 8, 2, 5, 64'h5500, 0, 20);
    expect_commit("ppC");
    read_check(0, 0, 4, NB, "ppC");

    // Invalid config (n_c = 0), then a valid restart
    do_start({12'd2, 10'd2, 10'd5}, 1'b0);
    chk("err_cfg_err", 64'(cfg_err), 64'd1);
    chk("err_s_ready", 64'(s_ready), 64'd0);
    do_start({12'd8, 10'd2, 10'd5}, 1'b0);
    chk("err_cleared", 64'(cfg_err), 64'd0);
    chk("err_s_ready_back", 64'(s_ready), 64'd1);

    // Overflow: 257 words to bank 0 in a 256-word half
    do_start({12'd4, 10'd257, 10'd1}, 1'b0);
    send_frame(1'b0, 4, 257, 1, 64'h6000, 0, 256);
    chk("ovf_not_yet", 64'(ovf), 64'd0);
    send_frame(1'b0, 4, 257, 1, 64'h6000, 256, 257);
    chk("ovf_set", 64'(ovf), 64'd1);
    expect_commit("ovf");
    read_check(0, 0, 2, 1, "ovf_lo");
    read_check(0, 252, 4, 1, "ovf_hi");
    do_start({12'd8, 10'd2, 10'd5}, 1'b0);
    chk("ovf_cleared", 64'(ovf), 64'd0);

    // Restart mid-frame: partial frame discarded, only the new frame commits
    fd0 = fd_count;
    send_frame(1'b0, 8, 2, 5, 64'h7700, 0, 7);
    do_start({12'd8, 10'd2, 10'd5}, 1'b0);
    chk("mid_rd_valid", 64'(rd_valid), 64'd0);
    send_frame(1'b0, 8, 2, 5, 64'h8800, 0, 20);
    expect_commit("mid");
    repeat (3) @(negedge clk);
    chk("mid_fd_count", 64'(fd_count - fd0), 64'd1);
    read_check(0, 0, 4, NB, "mid");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
